uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, frame size and default watchdog length.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int unsigned UART_FRAME_BITS = 10;

  // Two full frame times at the given clock and baud rate.
  function automatic int unsigned default_timeout(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
    return (2 * UART_FRAME_BITS * clk_freq) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index searching upward from last+1 with wrap.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int unsigned IW = $clog2(NREQ);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!any && valid[IW'((32'(last) + k) % NREQ)]) begin
        idx = IW'((32'(last) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters,
// with locked multi-byte packets and a completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned CLK_FREQ    = 1000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned TIMEOUT_CYC = default_timeout(CLK_FREQ, BAUD_RATE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              dintx,
  output logic                    newd,
  input  logic                    donetx,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          lock;
  logic          donetx_q;
  logic [WW-1:0] wdog;
  logic [7:0]    data_arr [NREQ];
  logic          done_rise_c;
  logic          grant_go_c;
  logic [IW-1:0] grant_sel_c;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[8*i +: 8];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A held lock pins the grant to the locked requester, even if it is idle.
  assign grant_go_c  = lock ? req_valid[grant_id] : pick_any;
  assign grant_sel_c = lock ? grant_id : pick_idx;
  assign done_rise_c = donetx & ~donetx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      newd        <= 1'b0;
      dintx       <= 8'h00;
      req_ready   <= '0;
      grant_id    <= '0;
      last_grant  <= IW'(NREQ - 1);
      lock        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      donetx_q    <= 1'b0;
      wdog        <= '0;
    end else begin
      donetx_q    <= donetx;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_go_c) begin
            dintx    <= data_arr[grant_sel_c];
            newd     <= 1'b1;
            grant_id <= grant_sel_c;
            wdog     <= '0;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (wdog != WW'(TIMEOUT_CYC)) wdog <= wdog + WW'(1);
          if (done_rise_c) begin
            newd                <= 1'b0;
            req_ready[grant_id] <= 1'b1;
            lock                <= ~req_last[grant_id];
            last_grant          <= grant_id;
            state               <= GAP;
          end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
            newd                <= 1'b0;
            req_ready[grant_id] <= 1'b1;
            timeout_err         <= 1'b1;
            lock                <= 1'b0;
            state               <= GAP;
          end
        end
        GAP: begin
          // Stale high donetx must not complete the next grant.
          if (!donetx) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
